// File: rtl/digit_scan_if.sv
// Display-scan bundle: scan controls in, digit select and strobes out.
// The master is the scan controller; the slave is the host/display side.
interface digit_scan_if;
    logic       en;         // advance scanning when high
    logic [3:0] digit_en;   // per-digit participation mask
    logic [1:0] sel;        // active digit index, drives the nibble mux
    logic [3:0] an;         // active-low one-hot digit strobes
    logic       slot_tick;  // one-cycle pulse on the last cycle of a slot

    modport master (
        input  en,
        input  digit_en,
        output sel,
        output an,
        output slot_tick
    );

    modport slave (
        output en,
        output digit_en,
        input  sel,
        input  an,
        input  slot_tick
    );
endinterface

// File: rtl/digit_scan_ctrl.sv
// Time-multiplexed 4-digit display scanner. Each digit owns a slot of DIV
// cycles; the first GAP cycles of every slot are blanked to stop ghosting
// while the segment bus settles. Disabled digits are skipped at slot wrap.
module digit_scan_ctrl #(
    parameter int unsigned DIV = 100000,  // cycles per digit slot, 4..2^20
    parameter int unsigned GAP = 16       // blanked cycles per slot, 0..DIV-1
) (
    input  logic         clk,
    input  logic         reset,
    digit_scan_if.master bus
);

    localparam int unsigned   CW    = $clog2(DIV);
    localparam logic [CW-1:0] LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] GAP_C = CW'(GAP);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sel_q, sel_d;
    logic [1:0]    next_sel;
    logic          wrap;

    assign wrap = (cnt_q == LAST);

    // Pick the next enabled digit after the current one, wrapping round to
    // the current digit itself; with nothing enabled the index holds.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        next_sel = sel_q;
        if (bus.digit_en[sel_q + 2'd1]) begin
            next_sel = sel_q + 2'd1;
        end else if (bus.digit_en[sel_q + 2'd2]) begin
            next_sel = sel_q + 2'd2;
        end else if (bus.digit_en[sel_q + 2'd3]) begin
            next_sel = sel_q + 2'd3;
        end
    end

    // Slot counter and digit index advance only while enabled.
    always_comb begin
        cnt_d = cnt_q;
        sel_d = sel_q;
        if (bus.en) begin
            if (wrap) begin
                cnt_d = '0;
                sel_d = next_sel;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            cnt_q <= '0;
            sel_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
            sel_q <= sel_d;
        end
    end

    // Strobe decode: blank during the gap or when the held digit is masked.
    always_comb begin
        bus.an = 4'b1111;
        if ((cnt_q >= GAP_C) && bus.digit_en[sel_q]) begin
            bus.an[sel_q] = 1'b0;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.slot_tick = bus.en & wrap;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl with DIV=8, GAP=2.
module tb_digit_scan_ctrl;

    localparam int DIV = 8;
    localparam int GAP = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    digit_scan_if bus ();

    digit_scan_ctrl #(.DIV(DIV), .GAP(GAP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic [1:0] s,
                                 input logic [3:0] a, input logic t);
        check({tag, ".sel"}, 32'(bus.sel), 32'(s));
        check({tag, ".an"}, 32'(bus.an), 32'(a));
        check({tag, ".tick"}, 32'(bus.slot_tick), 32'(t));
    endtask

    // Expected strobe for a lit digit s at slot position c under mask m.
    function automatic logic [3:0] exp_an(input logic [1:0] s, input int c, input logic [3:0] m);
        logic [3:0] a;
        a = 4'b1111;
        if (c >= GAP && m[s]) a[s] = 1'b0;
        return a;
    endfunction

    // Check cycles c_lo..c_hi of a slot holding digit s, ticking after each.
    task automatic run_slot(input string tag, input logic [1:0] s, input int c_lo, input int c_hi);
        for (int c = c_lo; c <= c_hi; c++) begin
            check_outputs($sformatf("%s.s%0d.c%0d", tag, s, c), s,
                          exp_an(s, c, bus.digit_en), (c == DIV - 1));
            tick();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        bus.en       = 1'b1;
        bus.digit_en = 4'b1111;
        #1;

        // Reset: held for two edges with en=1, state stays at cnt=0/sel=0.
        tick();
        check_outputs("rst1", 2'd0, 4'b1111, 1'b0);
        tick();
        check_outputs("rst2", 2'd0, 4'b1111, 1'b0);
        reset = 1'b0;

        // All digits: hand-checked first slot, then sequence 0,1,2,3,0.
        check_outputs("all.c0", 2'd0, 4'b1111, 1'b0);
        tick();
        check_outputs("all.c1", 2'd0, 4'b1111, 1'b0);
        tick();
        check_outputs("all.c2", 2'd0, 4'b1110, 1'b0);
        tick();
        run_slot("all", 2'd0, 3, 7);
        check_outputs("all.s1c0", 2'd1, 4'b1111, 1'b0);
        tick();
        check_outputs("all.s1c1", 2'd1, 4'b1111, 1'b0);
        tick();
        check_outputs("all.s1c2", 2'd1, 4'b1101, 1'b0);
        tick();
        run_slot("all", 2'd1, 3, 7);
        run_slot("all", 2'd2, 0, 7);
        run_slot("all", 2'd3, 0, 7);
        run_slot("all", 2'd0, 0, 7);

        // Mask 0101: 0,2,0,2; digits 1 and 3 never strobed.
        bus.digit_en = 4'b0101;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            logic [1:0] s;
            s = (k % 2 == 0) ? 2'd0 : 2'd2;
            for (int c = 0; c < DIV; c++) begin
                check_outputs($sformatf("alt.k%0d.c%0d", k, c), s,
                              (c < GAP) ? 4'b1111 : ((s == 2'd0) ? 4'b1110 : 4'b1011),
                              (c == DIV - 1));
                check("alt.an13", 32'({bus.an[3], bus.an[1]}), 32'(2'b11));
                tick();
            end
        end

        // Empty mask: sel holds 0, always blank, tick still every slot.
        bus.digit_en = 4'b0000;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < DIV; c++) begin
                check_outputs($sformatf("none.k%0d.c%0d", k, c), 2'd0, 4'b1111, (c == DIV - 1));
                tick();
            end
        end

        // Freeze at cnt=5: outputs hold lit, no tick; wrap 3 edges after resume.
        bus.digit_en = 4'b1111;
        do_reset();
        run_slot("frz", 2'd0, 0, 4);
        bus.en = 1'b0;
        #1;
        for (int k = 0; k < 5; k++) begin
            check_outputs($sformatf("frz.hold%0d", k), 2'd0, 4'b1110, 1'b0);
            tick();
        end
        check_outputs("frz.after", 2'd0, 4'b1110, 1'b0);
        bus.en = 1'b1;
        #1;
        check_outputs("frz.c5", 2'd0, 4'b1110, 1'b0);
        tick();
        check_outputs("frz.c6", 2'd0, 4'b1110, 1'b0);
        tick();
        check_outputs("frz.c7", 2'd0, 4'b1110, 1'b1);
        tick();
        check_outputs("frz.wrap", 2'd1, 4'b1111, 1'b0);

        // Mid-slot reset at cnt=4, sel=2: slot abandoned, restart from 0/0.
        do_reset();
        run_slot("mrst", 2'd0, 0, 7);
        run_slot("mrst", 2'd1, 0, 7);
        run_slot("mrst", 2'd2, 0, 3);
        check_outputs("mrst.pre", 2'd2, 4'b1011, 1'b0);
        reset = 1'b1;
        tick();
        check_outputs("mrst.in", 2'd0, 4'b1111, 1'b0);
        reset = 1'b0;
        run_slot("mrst.after", 2'd0, 0, 7);
        check_outputs("mrst.next", 2'd1, 4'b1111, 1'b0);

        // Mask change at cnt=4, sel=2: blanks at once, sel moves at wrap only.
        do_reset();
        run_slot("chg", 2'd0, 0, 7);
        run_slot("chg", 2'd1, 0, 7);
        run_slot("chg", 2'd2, 0, 3);
        check_outputs("chg.pre", 2'd2, 4'b1011, 1'b0);
        bus.digit_en = 4'b1011;
        #1;
        check_outputs("chg.now", 2'd2, 4'b1111, 1'b0);
        run_slot("chg", 2'd2, 4, 7);
        check_outputs("chg.s3c0", 2'd3, 4'b1111, 1'b0);
        tick();
        tick();
        check_outputs("chg.s3c2", 2'd3, 4'b0111, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
